// File: rtl/uart_mul_frame_ctrl_if.sv
// UART-side handshake bundle for the multiplier frame controller.
//   rx_data/rx_valid : received byte and its one-cycle strobe
//   tx_data/tx_start : word and one-cycle request towards the transmitter
//   tx_busy/tx_done  : transmitter busy level and end-of-word pulse
// master: the frame controller. slave: the UART receiver/transmitter pair.
interface uart_mul_frame_ctrl_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic              tx_done;

  modport master (
    input  rx_data, rx_valid, tx_busy, tx_done,
    output tx_data, tx_start
  );

  modport slave (
    output rx_data, rx_valid, tx_busy, tx_done,
    input  tx_data, tx_start
  );
endinterface

// File: rtl/uart_mul_frame_ctrl.sv
// Frame controller between UART RX and UART TX: parses SYNC, A, B, multiplies A*B with a
// sequential shift-add unit (DATA_W cycles) and returns the product high word first.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   uart          : rx byte stream in, tx word/request out, tx busy/done in (master modport)
//   result        : last completed product, held until the next one completes
//   result_valid  : one-cycle pulse when result updates
//   busy          : high whenever the controller is not idle
//   frame_err     : one-cycle pulse when an inter-byte timeout aborts a frame
//   rx_drop       : one-cycle pulse when a byte arrives while multiplying or transmitting
module uart_mul_frame_ctrl #(
  parameter int unsigned       DATA_W      = 8,
  parameter logic [DATA_W-1:0] SYNC_WORD   = 8'hA5,
  parameter int unsigned       TIMEOUT_CYC = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  uart_mul_frame_ctrl_if.master   uart,
  output logic [2*DATA_W-1:0]     result,
  output logic                    result_valid,
  output logic                    busy,
  output logic                    frame_err,
  output logic                    rx_drop
);
  localparam int unsigned PW   = 2 * DATA_W;
  localparam int unsigned CntW = $clog2(DATA_W + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC);
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    StIdle, StGetA, StGetB, StMul, StSendHi, StWaitHi, StSendLo, StWaitLo
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [PW-1:0]     acc_q, acc_d, acc_step;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [TmoW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [PW-1:0]     result_q, result_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              result_valid_q, result_valid_d;
  logic              busy_q, busy_d;
  logic              frame_err_q, frame_err_d;
  logic              rx_drop_q, rx_drop_d;

  always_comb begin
    state_d        = state_q;
    a_d            = a_q;
    mcand_d        = mcand_q;
    mplier_d       = mplier_q;
    acc_d          = acc_q;
    bit_cnt_d      = bit_cnt_q;
    tmo_cnt_d      = tmo_cnt_q;
    result_d       = result_q;
    tx_data_d      = tx_data_q;
    tx_start_d     = 1'b0;
    result_valid_d = 1'b0;
    frame_err_d    = 1'b0;
    rx_drop_d      = 1'b0;
    acc_step       = acc_q + (mplier_q[0] ? mcand_q : '0);

    case (state_q)
      StIdle: begin
        if (uart.rx_valid && (uart.rx_data == SYNC_WORD)) begin
          state_d   = StGetA;
          tmo_cnt_d = '0;
        end
      end
      StGetA: begin
        // A byte equal to SYNC_WORD here is operand data, not a resync.
        if (uart.rx_valid) begin
          a_d       = uart.rx_data;
          tmo_cnt_d = '0;
          state_d   = StGetB;
        end else if (tmo_cnt_q == TmoLast) begin
          frame_err_d = 1'b1;
          a_d         = '0;
          state_d     = StIdle;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TmoW'(1);
        end
      end
      StGetB: begin
        // A byte arriving in the expiry cycle wins over the timeout.
        if (uart.rx_valid) begin
          mcand_d   = PW'(a_q);
          mplier_d  = uart.rx_data;
          acc_d     = '0;
          bit_cnt_d = '0;
          state_d   = StMul;
        end else if (tmo_cnt_q == TmoLast) begin
          frame_err_d = 1'b1;
          a_d         = '0;
          state_d     = StIdle;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TmoW'(1);
        end
      end
      StMul: begin
        rx_drop_d = uart.rx_valid;
        acc_d     = acc_step;
        mcand_d   = mcand_q << 1;
        mplier_d  = mplier_q >> 1;
        if (bit_cnt_q == LastBit) begin
          result_d       = acc_step;
          result_valid_d = 1'b1;
          state_d        = StSendHi;
        end else begin
          bit_cnt_d = bit_cnt_q + CntW'(1);
        end
      end
      StSendHi: begin
        rx_drop_d = uart.rx_valid;
        tx_data_d = result_q[PW-1:DATA_W];
        if (!uart.tx_busy) begin
          tx_start_d = 1'b1;
          state_d    = StWaitHi;
        end
      end
      StWaitHi: begin
        rx_drop_d = uart.rx_valid;
        if (uart.tx_done) state_d = StSendLo;
      end
      StSendLo: begin
        rx_drop_d = uart.rx_valid;
        tx_data_d = result_q[DATA_W-1:0];
        if (!uart.tx_busy) begin
          tx_start_d = 1'b1;
          state_d    = StWaitLo;
        end
      end
      StWaitLo: begin
        rx_drop_d = uart.rx_valid;
        if (uart.tx_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      a_q            <= '0;
      mcand_q        <= '0;
      mplier_q       <= '0;
      acc_q          <= '0;
      bit_cnt_q      <= '0;
      tmo_cnt_q      <= '0;
      result_q       <= '0;
      tx_data_q      <= '0;
      tx_start_q     <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      frame_err_q    <= 1'b0;
      rx_drop_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      a_q            <= a_d;
      mcand_q        <= mcand_d;
      mplier_q       <= mplier_d;
      acc_q          <= acc_d;
      bit_cnt_q      <= bit_cnt_d;
      tmo_cnt_q      <= tmo_cnt_d;
      result_q       <= result_d;
      tx_data_q      <= tx_data_d;
      tx_start_q     <= tx_start_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
      frame_err_q    <= frame_err_d;
      rx_drop_q      <= rx_drop_d;
    end
  end

  assign uart.tx_data  = tx_data_q;
  assign uart.tx_start = tx_start_q;
  assign result        = result_q;
  assign result_valid  = result_valid_q;
  assign busy          = busy_q;
  assign frame_err     = frame_err_q;
  assign rx_drop       = rx_drop_q;
endmodule

// File: tb/tb_uart_mul_frame_ctrl.sv
// Directed bench for uart_mul_frame_ctrl with a small transmitter model answering tx_start.
module tb_uart_mul_frame_ctrl;
  localparam int unsigned DW  = 8;
  localparam int unsigned TMO = 40;

  logic            clk = 1'b0;
  logic            rst;
  logic [2*DW-1:0] result;
  logic            result_valid;
  logic            busy;
  logic            frame_err;
  logic            rx_drop;

  int n_assert = 0;
  int n_fail   = 0;

  uart_mul_frame_ctrl_if #(.DATA_W(DW)) uart ();

  uart_mul_frame_ctrl #(
    .DATA_W      (DW),
    .SYNC_WORD   (8'hA5),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .uart         (uart),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .frame_err    (frame_err),
    .rx_drop      (rx_drop)
  );

  always #5 clk = ~clk;

  // Event monitor, sampled on the falling edge.
  int            rv_cnt    = 0;
  int            fe_cnt    = 0;
  int            drop_cnt  = 0;
  int            start_cnt = 0;
  int            stab_err  = 0;
  int            dbl_err   = 0;
  logic          pending   = 1'b0;
  logic [DW-1:0] held      = '0;
  logic [DW-1:0] words[$];

  always @(negedge clk) begin
    if (result_valid) rv_cnt <= rv_cnt + 1;
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (rx_drop) drop_cnt <= drop_cnt + 1;
    if (rst) begin
      pending <= 1'b0;
    end else if (uart.tx_start) begin
      start_cnt <= start_cnt + 1;
      words.push_back(uart.tx_data);
      if (pending) dbl_err <= dbl_err + 1;
      pending <= 1'b1;
      held    <= uart.tx_data;
    end else if (pending) begin
      if (uart.tx_data !== held) stab_err <= stab_err + 1;
      if (uart.tx_done) pending <= 1'b0;
    end
  end

  // Transmitter model: tx_done three cycles after each tx_start.
  initial begin
    uart.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (uart.tx_start === 1'b1) begin
        repeat (3) @(posedge clk);
        #2 uart.tx_done = 1'b1;
        @(posedge clk);
        #2 uart.tx_done = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [DW-1:0] b);
    @(negedge clk);
    uart.rx_data  = b;
    uart.rx_valid = 1'b1;
    @(negedge clk);
    uart.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [DW-1:0] a, input logic [DW-1:0] b);
    send_byte(8'hA5);
    send_byte(a);
    send_byte(b);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_frame(input string tag, input logic [2*DW-1:0] exp,
                             input int rv0, input int w0);
    chk({tag, "_rv_count"}, rv_cnt - rv0, 32'd1);
    chk({tag, "_result"}, {16'd0, result}, {16'd0, exp});
    chk({tag, "_tx_words"}, words.size() - w0, 32'd2);
    if (words.size() >= w0 + 2) begin
      chk({tag, "_tx_hi"}, {24'd0, words[w0]}, {24'd0, exp[15:8]});
      chk({tag, "_tx_lo"}, {24'd0, words[w0+1]}, {24'd0, exp[7:0]});
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_result"}, {16'd0, result}, 32'd0);
    chk({tag, "_flags"}, {27'd0, result_valid, busy, frame_err, rx_drop, uart.tx_start},
        32'd0);
    chk({tag, "_tx_data"}, {24'd0, uart.tx_data}, 32'd0);
  endtask

  initial begin
    int rv0, w0, fe0, dr0, st0, n, hold_starts;
    logic was_busy;

    rst           = 1'b1;
    uart.rx_data  = '0;
    uart.rx_valid = 1'b0;
    uart.tx_busy  = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // Basic frame, with result_valid latency check.
    rv0 = rv_cnt; w0 = words.size();
    send_frame(8'h0C, 8'h0D);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!result_valid && n < 50);
    chk("t1_latency", n, DW);
    wait_idle("t1");
    check_frame("t1", 16'h009C, rv0, w0);

    // Extreme operands, then a zero operand.
    rv0 = rv_cnt; w0 = words.size();
    send_frame(8'hFF, 8'hFF);
    wait_idle("t2a");
    check_frame("t2a", 16'hFE01, rv0, w0);
    rv0 = rv_cnt; w0 = words.size();
    send_frame(8'h00, 8'h37);
    wait_idle("t2b");
    check_frame("t2b", 16'h0000, rv0, w0);

    // Non-sync bytes while idle are ignored silently.
    rv0 = rv_cnt; w0 = words.size(); fe0 = fe_cnt; dr0 = drop_cnt;
    send_byte(8'h3C);
    send_byte(8'h11);
    @(negedge clk);
    chk("t3_idle_after_junk", {31'd0, busy}, 32'd0);
    send_frame(8'h02, 8'h03);
    wait_idle("t3");
    check_frame("t3", 16'h0006, rv0, w0);
    chk("t3_no_drop", drop_cnt - dr0, 32'd0);
    chk("t3_no_ferr", fe_cnt - fe0, 32'd0);

    // Inter-byte timeout after operand A.
    rv0 = rv_cnt; fe0 = fe_cnt; st0 = start_cnt;
    send_byte(8'hA5);
    send_byte(8'h07);
    repeat (TMO - 5) @(negedge clk);
    chk("t4_no_early_ferr", fe_cnt - fe0, 32'd0);
    repeat (15) @(negedge clk);
    chk("t4_ferr_once", fe_cnt - fe0, 32'd1);
    chk("t4_idle", {31'd0, busy}, 32'd0);
    chk("t4_no_tx", start_cnt - st0, 32'd0);
    chk("t4_no_rv", rv_cnt - rv0, 32'd0);
    rv0 = rv_cnt; w0 = words.size();
    send_frame(8'h02, 8'h02);
    wait_idle("t4");
    check_frame("t4", 16'h0004, rv0, w0);

    // Transmitter busy delays tx_start; extra byte in WAIT_HI is dropped.
    rv0 = rv_cnt; w0 = words.size(); dr0 = drop_cnt;
    uart.tx_busy = 1'b1;
    send_frame(8'h03, 8'h05);
    n = 0;
    while (!result_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t5_rv_seen", {31'd0, result_valid}, 32'd1);
    hold_starts = 0;
    repeat (20) begin
      @(negedge clk);
      if (uart.tx_start) hold_starts++;
    end
    chk("t5_no_start_while_busy", hold_starts, 32'd0);
    uart.tx_busy = 1'b0;
    @(negedge clk);
    chk("t5_start_after_release", {31'd0, uart.tx_start}, 32'd1);
    send_byte(8'h77);
    wait_idle("t5");
    check_frame("t5", 16'h000F, rv0, w0);
    chk("t5_drop_once", drop_cnt - dr0, 32'd1);

    // Reset during the third multiply cycle.
    rv0 = rv_cnt; st0 = start_cnt;
    send_frame(8'h10, 8'h10);
    @(negedge clk);
    @(negedge clk);
    was_busy = busy;
    chk("t6_busy_before_rst", {31'd0, was_busy}, 32'd1);
    rst = 1'b1;
    #1;
    check_zero("t6_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("t6_no_rv_after_rst", rv_cnt - rv0, 32'd0);
    chk("t6_no_tx_after_rst", start_cnt - st0, 32'd0);
    chk("t6_idle_after_rst", {31'd0, busy}, 32'd0);
    rv0 = rv_cnt; w0 = words.size();
    send_frame(8'h10, 8'h10);
    wait_idle("t6");
    check_frame("t6", 16'h0100, rv0, w0);

    chk("tx_data_stable", stab_err, 32'd0);
    chk("no_double_start", dbl_err, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_mul_frame_ctrl.md
Name: uart_mul_frame_ctrl

Overview:
- Sits between the UART receiver and the UART transmitter in the multiplier/UART/SPI top.
- Consumes received bytes and parses a 3-byte frame: SYNC, operand A, operand B.
- Computes A*B with a sequential shift-add multiplier, then returns the product over the UART transmitter, most-significant word first.
- Also exposes the product and status pulses for the SPI side and the status outputs.

Parameters:
- DATA_W, 8, width of UART words and of each operand; product is 2*DATA_W.
- SYNC_WORD, 8'hA5, frame start marker (DATA_W bits).
- TIMEOUT_CYC, 50000, max clk cycles between frame bytes before abort; must be >= 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- rx_data  in  DATA_W  byte from UART receiver, valid when rx_valid=1
- rx_valid  in  1  one-cycle pulse per received byte
- tx_data  out  DATA_W  word to UART transmitter; held stable from tx_start until tx_done
- tx_start  out  1  one-cycle request to transmitter
- tx_busy  in  1  transmitter busy; tx_start is never issued while high
- tx_done  in  1  one-cycle pulse when the transmitter finishes a word
- result  out  2*DATA_W  last completed product; holds until the next product completes
- result_valid  out  1  one-cycle pulse when result updates
- busy  out  1  high in any state except IDLE
- frame_err  out  1  one-cycle pulse on inter-byte timeout
- rx_drop  out  1  one-cycle pulse when rx_valid arrives in MUL/SEND/WAIT states

Behaviour:
- Reset (async assert, sync release): state=IDLE, all outputs 0, operands/accumulator/counters 0.
- All outputs are registered.

State machine:
- IDLE:
  - rx_valid with rx_data==SYNC_WORD -> GET_A; clear timeout counter.
  - Other bytes are ignored silently (no rx_drop).
- GET_A:
  - rx_valid -> latch A, clear timeout counter, go to GET_B.
  - A byte equal to SYNC_WORD is accepted as data.
- GET_B:
  - rx_valid -> latch B, go to MUL; load multiplicand=A, multiplier=B, acc=0, bit_cnt=0.
- Timeout (GET_A and GET_B only):
  - Counter increments every cycle without rx_valid.
  - When the count reaches TIMEOUT_CYC-1 without a byte: pulse frame_err, go to IDLE, discard partial operands.
  - rx_valid in the same cycle as expiry wins: the byte is accepted, no error.
- MUL:
  - Exactly DATA_W cycles.
  - Each cycle: if multiplier LSB=1, acc += multiplicand (zero-extended to 2*DATA_W); multiplicand <<= 1; multiplier >>= 1.
  - After the DATA_W-th cycle: result<=acc, pulse result_valid, go to SEND_HI.
  - Latency: rx_valid of B in cycle 0 -> result_valid high in cycle DATA_W+1.
- SEND_HI:
  - tx_data<=result[2*DATA_W-1:DATA_W].
  - If tx_busy=0, pulse tx_start and go to WAIT_HI; otherwise stay.
  - Earliest tx_start is the cycle after result_valid.
- WAIT_HI: on tx_done -> SEND_LO.
- SEND_LO: same as SEND_HI with tx_data<=result[DATA_W-1:0]; goes to WAIT_LO.
- WAIT_LO: on tx_done -> IDLE.
- rx_valid in MUL/SEND_*/WAIT_*: byte discarded, rx_drop pulsed, no state change, no effect on result.
- tx_done outside WAIT_* is ignored.
- The multiplier is unsigned; no overflow is possible.

Mid-operation reset:
- Returns to IDLE immediately.
- result and flags clear to 0.
- tx_start deasserts in the same reset-assert instant.
- No partial frame survives.

Constraints:
- Never two tx_start pulses without an intervening tx_done.
- tx_data does not change between tx_start and the matching tx_done.

Test Plan:
- Frame A5,0C,0D with idle transmitter -> result_valid once, result=16'h009C, tx words 8'h00 then 8'h9C, busy falls after second tx_done.
- Frame A5,FF,FF -> result=16'hFE01, tx FE then 01; then A5,00,37 -> result=16'h0000, tx 00,00.
- Bytes 3C,11 then A5,02,03 -> first two ignored (no rx_drop, no frame_err), result=16'h0006.
- A5,07 then no byte for TIMEOUT_CYC cycles -> single frame_err pulse, busy=0, no tx_start; next A5,02,02 -> result=16'h0004.
- tx_busy held high 20 cycles after result_valid -> tx_start delayed until first cycle tx_busy=0; extra byte injected during WAIT_HI -> rx_drop pulse, transmitted words unchanged.
- rst asserted in MUL cycle 3 of frame A5,10,10 -> all outputs 0 at once; after release, frame A5,10,10 -> result=16'h0100.
